serial_slice_adder: RTL and testbench
=====================================

Name: serial_slice_adder

Overview:
Multi-cycle wide adder that feeds operands through a 4-bit ripple-carry slice, one slice per clock, least-significant slice first. The carry is registered between slices. Sits upstream of the result consumer with valid/ready on both sides. Lets the team build WIDTH-bit addition from the existing 4-bit ripple adder datapath at one slice of area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE and at least SLICE.
SLICE, 4, bits added per cycle (ripple slice width).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  addend A.
b  input  WIDTH  addend B.
cin  input  1  carry into slice 0.
out_valid  output  1  sum/cout hold a completed result.
out_ready  input  1  consumer takes the result.
sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
cout  output  1  carry out of the top slice.
busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Derived constant: NSLICE = WIDTH/SLICE.
- Reset (any state, including mid-RUN): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, slice index=0, carry reg=0. Any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, cin (cin into the carry reg), clear sum, set idx=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: sum[idx*SLICE +: SLICE] <= a_r slice + b_r slice + carry.
  - The carry reg takes the slice carry-out, and idx increments.
  - When idx==NSLICE-1 the slice is written, cout <= the slice carry-out, and the state goes to DONE.
- DONE:
  - out_valid=1; sum and cout are stable.
  - Stays in DONE while out_ready=0.
  - On out_ready=1: out_valid falls next edge, state goes to IDLE.
  - No same-cycle accept of new operands in DONE.
- Latency: out_valid rises exactly NSLICE rising edges after the accepting edge (4 for the defaults). Throughput is one result per NSLICE+2 cycles minimum.
- Operands arriving while in_ready=0 are ignored. a and b may change freely after acceptance because the block uses its latched copies.
- Arithmetic is unsigned. Overflow is reported only via cout, and sum wraps modulo 2^WIDTH.
- sum and cout keep their last values after the DONE→IDLE transition until the next accept clears sum.
- in_ready and out_valid are never high in the same cycle.

Decomposition:
- Package serial_slice_adder_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the NSLICE derivation function;
  - the index-width function clog2(NSLICE), minimum 1.
- Sub-module rca_slice is purely combinational:
  - inputs: SLICE-bit x, SLICE-bit y, ci;
  - outputs: SLICE-bit s, co;
  - built as a chain of full adders.
- One instance of rca_slice is muxed by idx. The FSM, operand registers and carry register live in the top module.

Test Plan:
- Plain add: a=0x1234, b=0x4321, cin=0 → out_valid 4 edges after accept; sum=0x5555, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1; per-slice trace shows the carry propagating through all 4 slices.
- Carry-in only: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Separately a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: sum/cout/out_valid stay stable and in_ready stays 0.
  - Assert out_ready: out_valid=0 and in_ready=1 on the next edge.
- Busy rejection: pulse in_valid with a=0x0F0F, b=0x0101 during RUN of 0x1111+0x2222 → result 0x3333, and the second operand pair is never accepted.
- Reset mid-operation: assert rst during the 2nd RUN cycle → next edge in_ready=1, out_valid=0, sum=0, cout=0. A following 0x8000+0x8000 yields sum=0x0000, cout=1.

Source files
------------

// File: rtl/serial_slice_adder_pkg.sv
// Shared types and elaboration helpers for the slice-serial wide adder.
// The FSM encoding and slice-count math live here so the top and any bench agree.
package serial_slice_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Index register width; a single-slice adder still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_slice_adder_rca_slice.sv
// Combinational SLICE-bit ripple-carry adder built from a chain of full adders.
// Reused once per cycle by the serial adder, selected by the slice index.
module rca_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] s_int;

  always_comb begin
    c     = '0;
    s_int = '0;
    c[0]  = ci;
    for (int i = 0; i < SLICE; i++) begin
      s_int[i] = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
  end

  assign s  = s_int;
  assign co = c[SLICE];

endmodule

// File: rtl/serial_slice_adder.sv
// WIDTH-bit unsigned adder that reuses one SLICE-bit ripple slice per clock,
// least-significant slice first, with valid/ready handshakes on both sides.
module serial_slice_adder
  import serial_slice_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDXW   = idx_w(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_width
    $error("serial_slice_adder: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic             accept, last;
  logic [SLICE-1:0] x_sl, y_sl, s_sl;
  logic             co_sl;

  // Single shared slice; operands come from the latched copies, not the ports.
  assign x_sl = a_r[int'(idx) * SLICE +: SLICE];
  assign y_sl = b_r[int'(idx) * SLICE +: SLICE];

  rca_slice #(.SLICE(SLICE)) u_slice (
    .x  (x_sl),
    .y  (y_sl),
    .ci (carry),
    .s  (s_sl),
    .co (co_sl)
  );

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture: plain data registers, only loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Slice sequencing: the carry register bridges consecutive slices.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      sum   <= '0;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[int'(idx) * SLICE +: SLICE] <= s_sl;
      carry <= co_sl;
      if (last) begin
        cout <= co_sl;
        idx  <= '0;
      end else begin
        idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_slice_adder.sv
// Scoreboard bench for serial_slice_adder: directed corner cases then random traffic.
module tb_serial_slice_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int tests = 0;
  int fails = 0;

  logic [W:0] exp_q[$];
  bit         rand_ready  = 1'b0;
  logic       ready_force = 1'b1;

  serial_slice_adder #(.WIDTH(W), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Consumer: either a fixed level chosen by the main sequence or random backpressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop one expected result per output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready && out_valid) check("ready_valid_exclusive", 32'd1, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {15'd0, cout, sum}, 32'hFFFF_FFFF);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("result_sum",  32'(sum),  32'(e[W-1:0]));
          check("result_cout", 32'(cout), 32'(e[W]));
        end
      end
    end
  end

  // Present one operand set and return just after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input bit push);
    int n = 0;
    logic [W:0] full;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    if (push) exp_q.push_back(full);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_sum",       32'(sum),       32'd0);
    check("reset_cout",      32'(cout),      32'd0);

    // Plain add with latency and busy observation
    send(16'h1234, 16'h4321, 1'b0, 1);
    check("run_busy",     32'(busy),     32'd1);
    check("run_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'd4);
    wait_idle();

    send(16'hFFFF, 16'h0001, 1'b0, 1);
    send(16'hFFFF, 16'h0000, 1'b1, 1);
    send(16'h0000, 16'h0000, 1'b1, 1);
    wait_idle();

    // Backpressure: result held stable while consumer stalls
    ready_force = 1'b0;
    send(16'h1357, 16'h2468, 1'b0, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_sum",       32'(sum),       32'h37BF);
      check("bp_cout",      32'(cout),      32'd0);
    end
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("hold_sum_after",    32'(sum),       32'h37BF);

    // Busy rejection: second operand pair offered during RUN is ignored
    send(16'h1111, 16'h2222, 1'b0, 1);
    a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("no_extra_valid", 32'(out_valid), 32'd0);
    check("no_extra_busy",  32'(busy),      32'd0);

    // Reset during the second RUN cycle discards the partial result
    send(16'h8001, 16'h8001, 1'b1, 1);
    wait_idle();
    send(16'hAAAA, 16'h5555, 1'b1, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum),       32'd0);
    check("midrst_cout",      32'(cout),      32'd0);
    rst = 1'b0;
    send(16'h8000, 16'h8000, 1'b0, 1);
    wait_idle();

    // Random traffic under random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1);
    end
    wait_idle();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
